// File: rtl/color_quant.sv
// Video colour quantiser: optional 2x2 ordered dither, then per-channel
// reduction to the three-level GA palette over a 2-stage pixel pipeline.

module cq_chan (
  input  logic [7:0] pix_i,
  input  logic [5:0] off_i,   // two's complement, -24..+24
  input  logic [7:0] adj1_i,  // stage-1 value to quantise
  input  logic       mode_i,
  output logic [7:0] adj_o,
  output logic [1:0] lvl_o
);
  logic [9:0] sum;
  logic [7:0] lo, hi;

  always_comb begin
    sum = {2'b00, pix_i} + {{4{off_i[5]}}, off_i};
    if (sum[9])      adj_o = 8'h00;
    else if (sum[8]) adj_o = 8'hFF;
    else             adj_o = sum[7:0];
  end

  always_comb begin
    lo = mode_i ? 8'h36 : 8'h37;
    hi = mode_i ? 8'hB3 : 8'hB1;
    if (adj1_i >= hi)      lvl_o = 2'b10;
    else if (adj1_i >= lo) lvl_o = 2'b01;
    else                   lvl_o = 2'b00;
  end
endmodule

module color_quant #(
  parameter int NUM_LANES = 3,
  parameter int VEC_W     = 8
) (
  input  logic       clk_vid,
  input  logic       reset_n,
  input  logic       ce_pix,
  input  logic       mode,
  input  logic       dither_en,
  input  logic [7:0] R_in,
  input  logic [7:0] G_in,
  input  logic [7:0] B_in,
  input  logic       HSync_in,
  input  logic       VSync_in,
  input  logic       HBlank_in,
  input  logic       VBlank_in,
  output logic [1:0] R_out,
  output logic [1:0] G_out,
  output logic [1:0] B_out,
  output logic [4:0] fw_colour,
  output logic       HSync_out,
  output logic       VSync_out,
  output logic       HBlank_out,
  output logic       VBlank_out,
  output logic       active_out
);
  // lane 2 = R, 1 = G, 0 = B
  logic [NUM_LANES-1:0][VEC_W-1:0] pix, adj_d, adj_q;
  logic [NUM_LANES-1:0][1:0]       lvl, code_d, code_q;
  logic [9:0] x_q, x_d;
  logic [8:0] y_q, y_d;
  logic       hb_prev_q;
  logic [5:0] off;
  logic       hs1_q, vs1_q, hb1_q, vb1_q, mode1_q;
  logic       hs2_q, vs2_q, hb2_q, vb2_q, act_q, act_d;
  logic [4:0] fw_q, fw_d;

  assign pix = {R_in, G_in, B_in};

  always_comb begin
    off = 6'd0;
    if (dither_en) begin
      case ({y_q[0], x_q[0]})
        2'b00:   off = 6'b101000; // -24
        2'b01:   off = 6'b001000; // +8
        2'b10:   off = 6'b011000; // +24
        default: off = 6'b111000; // -8
      endcase
    end
  end

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    cq_chan u_chan (
      .pix_i  (pix[i]),
      .off_i  (off),
      .adj1_i (adj_q[i]),
      .mode_i (mode1_q),
      .adj_o  (adj_d[i]),
      .lvl_o  (lvl[i])
    );
  end

  // Vertical clear wins over an HBlank rise in the same pixel.
  always_comb begin
    x_d = HBlank_in ? 10'd0 : x_q + 10'd1;
    if (VBlank_in)                   y_d = 9'd0;
    else if (HBlank_in && !hb_prev_q) y_d = y_q + 9'd1;
    else                             y_d = y_q;
  end

  always_comb begin
    act_d  = !(hb1_q || vb1_q);
    code_d = act_d ? lvl : '0;
    fw_d   = 5'd9 * {3'b000, code_d[1]} + 5'd3 * {3'b000, code_d[2]}
           + {3'b000, code_d[0]};
  end

  always_ff @(posedge clk_vid or negedge reset_n) begin
    if (!reset_n) begin
      x_q       <= '0;
      y_q       <= '0;
      hb_prev_q <= 1'b0;
      adj_q     <= '0;
      hs1_q     <= 1'b0;
      vs1_q     <= 1'b0;
      hb1_q     <= 1'b0;
      vb1_q     <= 1'b0;
      mode1_q   <= 1'b0;
      code_q    <= '0;
      fw_q      <= '0;
      hs2_q     <= 1'b0;
      vs2_q     <= 1'b0;
      hb2_q     <= 1'b0;
      vb2_q     <= 1'b0;
      act_q     <= 1'b0;
    end else if (ce_pix) begin
      x_q       <= x_d;
      y_q       <= y_d;
      hb_prev_q <= HBlank_in;
      adj_q     <= adj_d;
      hs1_q     <= HSync_in;
      vs1_q     <= VSync_in;
      hb1_q     <= HBlank_in;
      vb1_q     <= VBlank_in;
      mode1_q   <= mode;
      code_q    <= code_d;
      fw_q      <= fw_d;
      hs2_q     <= hs1_q;
      vs2_q     <= vs1_q;
      hb2_q     <= hb1_q;
      vb2_q     <= vb1_q;
      act_q     <= act_d;
    end
  end

  assign R_out      = code_q[2];
  assign G_out      = code_q[1];
  assign B_out      = code_q[0];
  assign fw_colour  = fw_q;
  assign HSync_out  = hs2_q;
  assign VSync_out  = vs2_q;
  assign HBlank_out = hb2_q;
  assign VBlank_out = vb2_q;
  assign active_out = act_q;
endmodule
